microarchtrace_pkt_decoder: RTL and testbench

//  Receiving end of the microarchitectural trace link: parses a byte stream of trace packets
//  (IF, IF_START, IF_END, IDEX, IDEX_MULT_END) into one event per packet.

---
 rtl/microarchtrace_pkt_decoder.sv | 232 +++++++++++++++++++++++
 tb/tb_microarchtrace_pkt_decoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/microarchtrace_pkt_decoder.sv
// Byte-stream trace packet decoder: header/pc/insn/c_insn parsing into a small event FIFO.
// Optional sequence checking is enabled by defining MATRACE_SEQ_CHECK_EN.
module microarchtrace_pkt_decoder #(
  parameter int EV_FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [2:0]  ev_type,
  output logic [31:0] ev_pc,
  output logic [31:0] ev_insn,
  output logic        ev_c,
  output logic [15:0] ev_c_insn,
  output logic        err_illegal,
  output logic        err_seq,
  output logic        err_timeout,
  output logic [1:0]  dbg_state
);

  // Handshakes: a byte moves when in_valid && in_ready; an event moves when ev_valid && ev_ready.
  typedef enum logic [1:0] {S_HDR = 2'd0, S_PC = 2'd1, S_INSN = 2'd2, S_CINSN = 2'd3} state_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        c;
    logic [15:0] c_insn;
  } ev_t;

  localparam int AW = $clog2(EV_FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(EV_FIFO_DEPTH);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [2:0]  r_type;
  logic        r_c;
  logic [31:0] r_pc;
  logic [31:0] r_insn;
  logic [7:0]  r_cinsn_lo;
  logic [15:0] r_to_cnt;
  logic        r_err_illegal;
  logic        r_err_timeout;

  ev_t         r_mem [EV_FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic        w_acc;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  ev_t         w_push_ev;
  ev_t         w_head;
  logic [2:0]  w_hdr_type;

  assign w_full     = (r_count == FULL_CNT);
  assign in_ready   = !w_full;
  assign w_acc      = in_valid && in_ready;
  assign ev_valid   = (r_count != '0);
  assign w_pop      = ev_valid && ev_ready;
  assign w_hdr_type = in_data[7:5];

  // Event assembly uses the in-flight byte so the push lands in the accepting cycle.
  always_comb begin
    w_push    = 1'b0;
    w_push_ev = '0;
    case (r_state)
      S_HDR: begin
        if (w_acc && w_hdr_type == 3'd1) begin
          w_push        = 1'b1;
          w_push_ev.typ = 3'd1;
        end
      end
      S_PC: begin
        if (w_acc && r_cnt == 2'd3 && r_type >= 3'd3) begin
          w_push        = 1'b1;
          w_push_ev.typ = r_type;
          w_push_ev.pc  = {in_data, r_pc[23:0]};
        end
      end
      S_INSN: begin
        if (w_acc && r_cnt == 2'd3 && !r_c) begin
          w_push         = 1'b1;
          w_push_ev.typ  = r_type;
          w_push_ev.pc   = r_pc;
          w_push_ev.insn = {in_data, r_insn[23:0]};
        end
      end
      S_CINSN: begin
        if (w_acc && r_cnt == 2'd1) begin
          w_push           = 1'b1;
          w_push_ev.typ    = r_type;
          w_push_ev.pc     = r_pc;
          w_push_ev.insn   = r_insn;
          w_push_ev.c      = 1'b1;
          w_push_ev.c_insn = {in_data, r_cinsn_lo};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_HDR;
      r_cnt         <= 2'd0;
      r_type        <= 3'd0;
      r_c           <= 1'b0;
      r_pc          <= 32'd0;
      r_insn        <= 32'd0;
      r_cinsn_lo    <= 8'd0;
      r_to_cnt      <= 16'd0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
      if (w_acc) begin
        r_to_cnt <= 16'd0;
        case (r_state)
          S_HDR: begin
            if (w_hdr_type >= 3'd5) begin
              r_err_illegal <= 1'b1;
            end else if (w_hdr_type != 3'd1) begin
              r_type  <= w_hdr_type;
              r_c     <= in_data[4] && (w_hdr_type == 3'd0 || w_hdr_type == 3'd2);
              r_state <= S_PC;
              r_cnt   <= 2'd0;
            end
          end
          S_PC: begin
            r_pc[{r_cnt, 3'b000} +: 8] <= in_data;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_cnt   <= 2'd0;
              r_state <= (r_type >= 3'd3) ? S_HDR : S_INSN;
            end
          end
          S_INSN: begin
            r_insn[{r_cnt, 3'b000} +: 8] <= in_data;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_cnt   <= 2'd0;
              r_state <= r_c ? S_CINSN : S_HDR;
            end
          end
          S_CINSN: begin
            r_cinsn_lo <= in_data;
            r_cnt      <= r_cnt + 2'd1;
            if (r_cnt == 2'd1) begin
              r_cnt   <= 2'd0;
              r_state <= S_HDR;
            end
          end
          default: r_state <= S_HDR;
        endcase
      end else if (TO_EN && r_state != S_HDR) begin
        // Stalls on a full FIFO count as idle; the partial packet is simply dropped.
        if (r_to_cnt == TO_LAST) begin
          r_state       <= S_HDR;
          r_cnt         <= 2'd0;
          r_to_cnt      <= 16'd0;
          r_err_timeout <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 16'd1;
        end
      end
    end
  end

`ifdef MATRACE_SEQ_CHECK_EN
  logic [3:0] r_exp_seq;
  logic       r_err_seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp_seq <= 4'd0;
      r_err_seq <= 1'b0;
    end else if (w_acc && r_state == S_HDR && w_hdr_type <= 3'd4) begin
      r_err_seq <= (in_data[3:0] != r_exp_seq);
      r_exp_seq <= in_data[3:0] + 4'd1;
    end else begin
      r_err_seq <= 1'b0;
    end
  end

  assign err_seq = r_err_seq;
`else
  assign err_seq = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_ev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs read as zero whenever the FIFO is empty, including straight out of reset.
  assign w_head      = ev_valid ? r_mem[r_rptr] : '0;
  assign ev_type     = w_head.typ;
  assign ev_pc       = w_head.pc;
  assign ev_insn     = w_head.insn;
  assign ev_c        = w_head.c;
  assign ev_c_insn   = w_head.c_insn;
  assign err_illegal = r_err_illegal;
  assign err_timeout = r_err_timeout;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_microarchtrace_pkt_decoder.sv
// Bench for microarchtrace_pkt_decoder: directed packets, expected-event queue, negedge monitor.
module tb_microarchtrace_pkt_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        ev_valid;
  logic        ev_ready;
  logic [2:0]  ev_type;
  logic [31:0] ev_pc;
  logic [31:0] ev_insn;
  logic        ev_c;
  logic [15:0] ev_c_insn;
  logic        err_illegal;
  logic        err_seq;
  logic        err_timeout;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ill    = 0;
  int n_seqe   = 0;
  int n_to     = 0;
  int exp_ill  = 0;
  int exp_seqe = 0;
  int exp_to   = 0;

  logic [83:0] exp_q[$];
  logic [83:0] mon_exp;
  logic [83:0] mon_act;

  microarchtrace_pkt_decoder #(.EV_FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type), .ev_pc(ev_pc),
    .ev_insn(ev_insn), .ev_c(ev_c), .ev_c_insn(ev_c_insn), .err_illegal(err_illegal),
    .err_seq(err_seq), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] insn,
                          input logic c, input logic [15:0] ci);
    exp_q.push_back({t, pc, insn, c, ci});
  endtask

  // Inputs change at posedge+1; a byte counts as accepted at the next posedge with in_ready high.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte_stall: in_ready 0 for %0d cycles, byte %0h", waited, b);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_drain(input string name);
    int waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(name, 96'(exp_q.size()), 96'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    ev_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (err_illegal) n_ill++;
      if (err_seq)     n_seqe++;
      if (err_timeout) n_to++;
      if (ev_valid && ev_ready) begin
        n_checks++;
        mon_act = {ev_type, ev_pc, ev_insn, ev_c, ev_c_insn};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ev_unexpected: got %0h expected no event", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            n_fail++;
            $display("FAIL ev_data: got %0h expected %0h", mon_act, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ev_ready = 1'b1;
    do_reset();
    chk("reset_ev_valid", 96'(ev_valid), 96'd0);
    chk("reset_in_ready", 96'(in_ready), 96'd1);
    chk("reset_ev_fields", 96'({ev_type, ev_pc, ev_insn, ev_c, ev_c_insn}), 96'd0);
    chk("reset_errs", 96'({err_illegal, err_seq, err_timeout}), 96'd0);
    chk("reset_state", 96'(dbg_state), 96'd0);

    // 1: IF, c=0
    push_exp(3'd0, 32'h8000_0100, 32'h0010_0513, 1'b0, 16'h0);
    send_byte(8'h00);
    send_word(32'h8000_0100);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10);
    chk("t1_no_early_valid", 96'(ev_valid), 96'd0);
    send_byte(8'h00);
    chk("t1_latency", 96'(ev_valid), 96'd1);
    wait_drain("t1_drain");

    // 2: IF_END with compressed insn
    do_reset();
    push_exp(3'd2, 32'h8000_0104, 32'h0, 1'b1, 16'h4505);
    send_byte(8'h50);
    send_word(32'h8000_0104);
    send_word(32'h0);
    send_byte(8'h05); send_byte(8'h45);
    wait_drain("t2_drain");

    // 3: FIFO fill with sink stalled, then drain in order
    do_reset();
    ev_ready = 1'b0;
    push_exp(3'd1, 32'h0, 32'h0, 1'b0, 16'h0);
    push_exp(3'd3, 32'h8000_0100, 32'h0, 1'b0, 16'h0);
    push_exp(3'd1, 32'h0, 32'h0, 1'b0, 16'h0);
    push_exp(3'd3, 32'h8000_0200, 32'h0, 1'b0, 16'h0);
    push_exp(3'd1, 32'h0, 32'h0, 1'b0, 16'h0);
    send_byte(8'h20);
    send_byte(8'h61); send_word(32'h8000_0100);
    send_byte(8'h22);
    send_byte(8'h63); send_word(32'h8000_0200);
    chk("t3_full_in_ready", 96'(in_ready), 96'd0);
    chk("t3_head_type", 96'(ev_type), 96'd1);
    fork
      send_byte(8'h24);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("t3_hold_valid", 96'(ev_valid), 96'd1);
        chk("t3_hold_head", 96'({ev_type, ev_pc}), 96'({3'd1, 32'h0}));
        ev_ready = 1'b1;
      end
    join
    wait_drain("t3_drain");

    // 4: illegal header then IDEX
    do_reset();
    push_exp(3'd3, 32'h8000_0100, 32'h0, 1'b0, 16'h0);
    send_byte(8'hA0);
    chk("t4_illegal_pulse", 96'(err_illegal), 96'd1);
    chk("t4_state_hdr", 96'(dbg_state), 96'd0);
    exp_ill++;
    send_byte(8'h60); send_word(32'h8000_0100);
    wait_drain("t4_drain");
    chk("t4_illegal_count", 96'(n_ill), 96'(exp_ill));
    chk("t4_seq_count", 96'(n_seqe), 96'(exp_seqe));

    // 5: sequence 0,1,3,4
    do_reset();
    for (int i = 0; i < 4; i++) push_exp(3'd1, 32'h0, 32'h0, 1'b0, 16'h0);
    send_byte(8'h20);
    send_byte(8'h21);
    send_byte(8'h23);
`ifdef MATRACE_SEQ_CHECK_EN
    chk("t5_seq_pulse", 96'(err_seq), 96'd1);
    exp_seqe++;
`endif
    send_byte(8'h24);
    chk("t5_seq_resync", 96'(err_seq), 96'd0);
    wait_drain("t5_drain");
    chk("t5_seq_count", 96'(n_seqe), 96'(exp_seqe));

    // 6: timeout mid-packet, recovery, then reset mid-packet
    do_reset();
    send_byte(8'h60); send_byte(8'h00); send_byte(8'h01);
    repeat (7) @(posedge clk);
    #1;
    chk("t6_no_early_timeout", 96'(n_to), 96'(exp_to));
    repeat (2) @(posedge clk);
    #1;
    exp_to++;
    chk("t6_timeout_count", 96'(n_to), 96'(exp_to));
    chk("t6_state_hdr", 96'(dbg_state), 96'd0);
    chk("t6_no_event", 96'(ev_valid), 96'd0);
    push_exp(3'd3, 32'h8000_0200, 32'h0, 1'b0, 16'h0);
    send_byte(8'h61); send_word(32'h8000_0200);
    wait_drain("t6_recover_drain");
    chk("t6_seq_count", 96'(n_seqe), 96'(exp_seqe));

    ev_ready = 1'b0;
    push_exp(3'd3, 32'h1234_5678, 32'h0, 1'b0, 16'h0);
    send_byte(8'h62); send_word(32'h1234_5678);
    send_byte(8'h03); send_byte(8'h11);
    chk("t6_pre_reset_valid", 96'(ev_valid), 96'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 96'(ev_valid), 96'd0);
    chk("t6_async_fields", 96'({ev_type, ev_pc, ev_insn, ev_c, ev_c_insn}), 96'd0);
    chk("t6_async_state", 96'(dbg_state), 96'd0);
    do_reset();
    push_exp(3'd4, 32'h8000_0300, 32'h0, 1'b0, 16'h0);
    send_byte(8'h80); send_word(32'h8000_0300);
    wait_drain("t6_post_reset_drain");

    chk("final_illegal_count", 96'(n_ill), 96'(exp_ill));
    chk("final_seq_count", 96'(n_seqe), 96'(exp_seqe));
    chk("final_timeout_count", 96'(n_to), 96'(exp_to));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
